// File: rtl/video_decimator_wr.sv
// -----------------------------------------------------------------------------
// video_decimator_wr
//
// Purpose:
//   Decimates a DVI-decoded pixel stream by H_DIV x V_DIV and converts each
//   kept pixel to RGB888, RGB565 or GRAY8. Every kept pixel becomes a
//   frame-buffer BRAM write (address + data + write strobe). One output row
//   takes OUT_COLS words of address space, so a short input line leaves a
//   hole and later rows are never shifted.
//
// Ports:
//   i_Clk        pixel clock, sole clock
//   rstb         asynchronous active-low reset
//   i_Hsync      horizontal sync, only delayed to o_HSync
//   i_Vsync      vertical sync, active level VS_POL
//   i_Vde        active-video qualifier
//   i_Data       pixel {R,G,B}
//   i_Enable     capture enable, sampled at frame start
//   i_Mode       0 RGB888, 1 RGB565, 2 GRAY8, 3 same as 0; sampled at frame start
//   o_We         BRAM write strobe
//   o_Addr       BRAM word address
//   o_Data       converted pixel, unused MSBs zero
//   o_HSync      i_Hsync delayed to line up with o_We
//   o_Frame_Done one-cycle pulse at the end of a captured frame
//   o_Frame_Cnt  captured-frame counter, wraps
//   o_Overflow   set when a line or the frame held more kept pixels than fit;
//                cleared at the next frame start
// -----------------------------------------------------------------------------
module video_decimator_wr #(
  parameter int H_DIV    = 3,
  parameter int V_DIV    = 3,
  parameter int OUT_COLS = 426,
  parameter int OUT_ROWS = 240,
  parameter int ADDR_W   = 24,
  parameter bit VS_POL   = 1'b1
) (
  input  logic              i_Clk,
  input  logic              rstb,
  input  logic              i_Hsync,
  input  logic              i_Vsync,
  input  logic              i_Vde,
  input  logic [23:0]       i_Data,
  input  logic              i_Enable,
  input  logic [1:0]        i_Mode,
  output logic              o_We,
  output logic [ADDR_W-1:0] o_Addr,
  output logic [23:0]       o_Data,
  output logic              o_HSync,
  output logic              o_Frame_Done,
  output logic [15:0]       o_Frame_Cnt,
  output logic              o_Overflow
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACT = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam int HW = (H_DIV > 1) ? $clog2(H_DIV) : 1;
  localparam int VW = (V_DIV > 1) ? $clog2(V_DIV) : 1;
  localparam int CW = $clog2(OUT_COLS + 1);
  localparam int RW = $clog2(OUT_ROWS + 1);

  localparam logic [HW-1:0]     H_LAST  = HW'(H_DIV - 1);
  localparam logic [VW-1:0]     V_LAST  = VW'(V_DIV - 1);
  localparam logic [CW-1:0]     COL_LIM = CW'(OUT_COLS);
  localparam logic [RW-1:0]     ROW_LIM = RW'(OUT_ROWS);
  localparam logic [ADDR_W-1:0] PITCH   = ADDR_W'(OUT_COLS);

  logic [1:0]        state_q, state_d;
  logic              vs_act_q, vs_act_d;
  logic              vde_q, vde_d;
  logic [HW-1:0]     hph_q, hph_d;
  logic [VW-1:0]     vph_q, vph_d;
  logic [CW-1:0]     out_col_q, out_col_d;
  logic [RW-1:0]     out_row_q, out_row_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              done_q, done_d;

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [23:0]       s1_pix_q, s1_pix_d;
  logic [1:0]        s1_mode_q, s1_mode_d;
  logic              s1_hs_q, s1_hs_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       data_q, data_d;
  logic              hs_q, hs_d;

  logic              vs_act;
  logic              frame_start;
  logic              vde_fall;
  logic              capturing;
  logic              phase_hit;
  logic              in_range;
  logic [15:0]       gray_sum;
  logic [23:0]       conv_pix;

  assign o_We         = we_q;
  assign o_Addr       = addr_q;
  assign o_Data       = data_q;
  assign o_HSync      = hs_q;
  assign o_Frame_Done = done_q;
  assign o_Frame_Cnt  = frame_cnt_q;
  assign o_Overflow   = ovf_q;

  // Pixel conversion for the second pipeline stage, using the mode that was
  // in force when the pixel was selected.
  always_comb begin
    gray_sum = 16'd77  * {8'd0, s1_pix_q[23:16]}
             + 16'd150 * {8'd0, s1_pix_q[15:8]}
             + 16'd29  * {8'd0, s1_pix_q[7:0]};
    case (s1_mode_q)
      2'd1:    conv_pix = {8'd0, s1_pix_q[23:19], s1_pix_q[15:10], s1_pix_q[7:3]};
      2'd2:    conv_pix = {16'd0, gray_sum[15:8]};
      default: conv_pix = s1_pix_q;
    endcase
  end

  always_comb begin
    vs_act      = (i_Vsync == VS_POL);
    frame_start = vs_act && !vs_act_q;
    vde_fall    = vde_q && !i_Vde;
    // WAIT_ACT counts as capturing so the very first active pixel is kept.
    capturing   = (state_q == ST_WAIT_ACT) || (state_q == ST_ACTIVE);
    phase_hit   = capturing && i_Vde && (hph_q == '0) && (vph_q == '0);
    in_range    = (out_col_q < COL_LIM) && (out_row_q < ROW_LIM);

    state_d     = state_q;
    vs_act_d    = vs_act;
    vde_d       = i_Vde;
    hph_d       = hph_q;
    vph_d       = vph_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    line_base_d = line_base_q;
    ovf_d       = ovf_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE:     if (frame_start && i_Enable) state_d = ST_WAIT_ACT;
      // A frame start before any active video is an empty frame: stay put.
      ST_WAIT_ACT: if (!frame_start && i_Vde) state_d = ST_ACTIVE;
      ST_ACTIVE:   if (frame_start) state_d = ST_DONE;
      default:     state_d = i_Enable ? ST_WAIT_ACT : ST_IDLE;
    endcase

    if (state_q == ST_ACTIVE && frame_start) begin
      done_d      = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    if (vde_fall) begin
      hph_d = '0;
    end else if (i_Vde) begin
      hph_d = (hph_q == H_LAST) ? '0 : hph_q + HW'(1);
    end

    if (frame_start) begin
      vph_d = '0;
    end else if (vde_fall) begin
      vph_d = (vph_q == V_LAST) ? '0 : vph_q + VW'(1);
    end

    // out_col saturates at the limit so an over-long line cannot wrap back
    // into the valid range.
    if (frame_start || vde_fall) begin
      out_col_d = '0;
    end else if (phase_hit && out_col_q < COL_LIM) begin
      out_col_d = out_col_q + CW'(1);
    end

    // The line base advances by a full pitch after every kept row, however
    // many pixels that row actually delivered.
    if (frame_start) begin
      out_row_d   = '0;
      line_base_d = '0;
    end else if (vde_fall && capturing && vph_q == '0 && out_row_q < ROW_LIM) begin
      out_row_d   = out_row_q + RW'(1);
      line_base_d = line_base_q + PITCH;
    end

    if (frame_start) begin
      ovf_d  = 1'b0;
      mode_d = (i_Mode == 2'd3) ? 2'd0 : i_Mode;
    end else if (phase_hit && !in_range) begin
      ovf_d = 1'b1;
    end

    s1_valid_d = phase_hit && in_range;
    s1_addr_d  = s1_addr_q;
    s1_pix_d   = s1_pix_q;
    s1_mode_d  = s1_mode_q;
    s1_hs_d    = i_Hsync;
    if (phase_hit && in_range) begin
      s1_addr_d = line_base_q + ADDR_W'(out_col_q);
      s1_pix_d  = i_Data;
      s1_mode_d = mode_q;
    end

    // Address/data hold their last value between writes.
    we_d   = s1_valid_q;
    addr_d = addr_q;
    data_d = data_q;
    hs_d   = s1_hs_q;
    if (s1_valid_q) begin
      addr_d = s1_addr_q;
      data_d = conv_pix;
    end
  end

  // vs_act_q resets to "already active" so a sync held at its active level
  // through reset is not mistaken for a fresh frame start.
  always_ff @(posedge i_Clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      vs_act_q    <= 1'b1;
      vde_q       <= 1'b0;
      hph_q       <= '0;
      vph_q       <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      line_base_q <= '0;
      ovf_q       <= 1'b0;
      mode_q      <= 2'd0;
      frame_cnt_q <= 16'd0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_pix_q    <= 24'd0;
      s1_mode_q   <= 2'd0;
      s1_hs_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= 24'd0;
      hs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_act_q    <= vs_act_d;
      vde_q       <= vde_d;
      hph_q       <= hph_d;
      vph_q       <= vph_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      line_base_q <= line_base_d;
      ovf_q       <= ovf_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_pix_q    <= s1_pix_d;
      s1_mode_q   <= s1_mode_d;
      s1_hs_q     <= s1_hs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      hs_q        <= hs_d;
    end
  end

endmodule
